// File: rtl/l2_mem_responder.sv
// l2_mem_responder: word-addressed backing store answering dcache LOAD/STORE
// requests after a fixed latency, with a one-cycle completion pulse.
// Words never written since reset read back as FILL_WORD.
// Optional build macro L2_MEM_STATS_EN adds saturating load/store counters.

package l2_mem_pkg;
   typedef enum logic [1:0] {
      LOAD  = 2'b00,
      STORE = 2'b01
   } memory_operation_e;
endpackage

module l2_mem_responder
   import l2_mem_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     NUM_WORDS = 1024,
   parameter int unsigned     LATENCY   = 4,
   parameter logic [XLEN-1:0] FILL_WORD = 32'hABAC_0012
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   l2_req_address,
   input  memory_operation_e l2_req_type,
   input  logic              l2_req_valid,
   input  logic [XLEN-1:0]   l2_word_to_store,
   output logic [XLEN-1:0]   l2_fetched_word,
   output logic              l2_req_fulfilled
`ifdef L2_MEM_STATS_EN
   ,
   output logic [31:0]       load_count,
   output logic [31:0]       store_count
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      RESPOND = 2'b10
   } state_e;

   state_e            state, state_next;
   logic [3:0]        cnt, cnt_next;

   logic [IDX_W-1:0]  lat_idx;
   memory_operation_e lat_type;
   logic [XLEN-1:0]   lat_data;

   logic [IDX_W-1:0]  cur_idx;
   memory_operation_e cur_type;
   logic [XLEN-1:0]   cur_data;

   logic              enter_respond;
   logic              do_store;
   logic              do_load;

   logic [XLEN-1:0]   mem [NUM_WORDS];
   logic [NUM_WORDS-1:0] written;

   // Address bits outside the word index are deliberately ignored (aliasing).
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{l2_req_address[XLEN-1:IDX_W+2], l2_req_address[1:0]};

   // With LATENCY=1 the response is produced on the acceptance edge itself,
   // before the latches hold the request, so the live inputs are used in IDLE.
   always_comb begin
      cur_idx  = lat_idx;
      cur_type = lat_type;
      cur_data = lat_data;
      if (state == IDLE) begin
         cur_idx  = l2_req_address[IDX_W+1:2];
         cur_type = l2_req_type;
         cur_data = l2_word_to_store;
      end
   end

   assign enter_respond = (state_next == RESPOND) && (state != RESPOND) && !reset;
   assign do_store      = enter_respond && (cur_type == STORE);
   assign do_load       = enter_respond && (cur_type != STORE);

   // State register and latency counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: accept, count down, abort on dropped valid, respond once.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (l2_req_valid) begin
               if (LATENCY == 1) begin
                  state_next = RESPOND;
                  cnt_next   = '0;
               end else begin
                  state_next = WAIT;
                  cnt_next   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (!l2_req_valid) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt <= 4'd1) begin
               state_next = RESPOND;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         RESPOND: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Output logic: completion pulse for the single RESPOND cycle.
   always_comb begin
      l2_req_fulfilled = 1'b0;
      if (state == RESPOND) l2_req_fulfilled = 1'b1;
   end

   // Request latches, captured on the acceptance edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_idx  <= '0;
         lat_type <= LOAD;
         lat_data <= '0;
      end else if (state == IDLE && l2_req_valid) begin
         lat_idx  <= l2_req_address[IDX_W+1:2];
         lat_type <= l2_req_type;
         lat_data <= l2_word_to_store;
      end
   end

   // Backing store array; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_store) mem[cur_idx] <= cur_data;
   end

   // Per-word written flags; cleared by reset so stale data reads as fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         written <= '0;
      end else if (do_store) begin
         written[cur_idx] <= 1'b1;
      end
   end

   // Load data register; holds across stores and idle periods.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l2_fetched_word <= '0;
      end else if (do_load) begin
         l2_fetched_word <= written[cur_idx] ? mem[cur_idx] : FILL_WORD;
      end
   end

`ifdef L2_MEM_STATS_EN
   // Saturating completion counters; unknown types complete as loads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_count  <= '0;
         store_count <= '0;
      end else begin
         if (do_load && load_count != '1)   load_count  <= load_count + 32'd1;
         if (do_store && store_count != '1) store_count <= store_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed self-checking bench for l2_mem_responder (LATENCY=4, 1024 words).
// Define L2_MEM_STATS_EN for both files to exercise the counter outputs.

module tb_l2_mem_responder;
   import l2_mem_pkg::*;

   localparam int unsigned LAT  = 4;
   localparam logic [31:0] FILL = 32'hABAC_0012;

   logic              clk;
   logic              reset;
   logic [31:0]       l2_req_address;
   memory_operation_e l2_req_type;
   logic              l2_req_valid;
   logic [31:0]       l2_word_to_store;
   logic [31:0]       l2_fetched_word;
   logic              l2_req_fulfilled;
`ifdef L2_MEM_STATS_EN
   logic [31:0]       load_count;
   logic [31:0]       store_count;
`endif

   int checks   = 0;
   int failures = 0;

   l2_mem_responder #(
      .XLEN      (32),
      .NUM_WORDS (1024),
      .LATENCY   (LAT),
      .FILL_WORD (FILL)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .l2_req_address   (l2_req_address),
      .l2_req_type      (l2_req_type),
      .l2_req_valid     (l2_req_valid),
      .l2_word_to_store (l2_word_to_store),
      .l2_fetched_word  (l2_fetched_word),
      .l2_req_fulfilled (l2_req_fulfilled)
`ifdef L2_MEM_STATS_EN
      ,
      .load_count       (load_count),
      .store_count      (store_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, check the pulse lands exactly on edge LAT and is one cycle wide.
   task automatic run_req(input string tag, input memory_operation_e t,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_f);
      @(negedge clk);
      l2_req_type      = t;
      l2_req_address   = a;
      l2_word_to_store = d;
      l2_req_valid     = 1'b1;
      for (int k = 1; k <= int'(LAT); k++) begin
         @(posedge clk); #1;
         chk({tag, "_pulse"}, {31'b0, l2_req_fulfilled}, (k == int'(LAT)) ? 32'd1 : 32'd0);
      end
      chk({tag, "_data"}, l2_fetched_word, exp_f);
      @(negedge clk);
      l2_req_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_width"}, {31'b0, l2_req_fulfilled}, 32'd0);
      chk({tag, "_hold"}, l2_fetched_word, exp_f);
   endtask

   initial begin
      reset            = 1'b1;
      l2_req_valid     = 1'b0;
      l2_req_type      = LOAD;
      l2_req_address   = '0;
      l2_word_to_store = '0;
      #1;
      chk("rst_pulse", {31'b0, l2_req_fulfilled}, 32'd0);
      chk("rst_fetched", l2_fetched_word, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Fill word for untouched location, store does not disturb fetched word.
      run_req("load40_fill", LOAD, 32'h0000_0040, 32'h0, FILL);
      run_req("store40", STORE, 32'h0000_0040, 32'hDEAD_BEEF, FILL);
      run_req("load43", LOAD, 32'h0000_0043, 32'h0, 32'hDEAD_BEEF);

      // Alias wrap: 0x1044 and 0x44 map to the same word.
      run_req("store1044", STORE, 32'h0000_1044, 32'h1234_5678, 32'hDEAD_BEEF);
      run_req("load44_alias", LOAD, 32'h0000_0044, 32'h0, 32'h1234_5678);

      // Abort: valid dropped so the second WAIT edge samples it low.
      @(negedge clk);
      l2_req_type    = LOAD;
      l2_req_address = 32'h0000_0040;
      l2_req_valid   = 1'b1;
      @(posedge clk); #1;
      chk("abort_e1", {31'b0, l2_req_fulfilled}, 32'd0);
      @(posedge clk); #1;
      chk("abort_e2", {31'b0, l2_req_fulfilled}, 32'd0);
      @(negedge clk);
      l2_req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("abort_nopulse", {31'b0, l2_req_fulfilled}, 32'd0);
      end
      chk("abort_fetched", l2_fetched_word, 32'h1234_5678);
      run_req("load40_after_abort", LOAD, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);

      // Reset in the middle of a STORE's wait.
      @(negedge clk);
      l2_req_type      = STORE;
      l2_req_address   = 32'h0000_0080;
      l2_word_to_store = 32'h5555_AAAA;
      l2_req_valid     = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_pulse", {31'b0, l2_req_fulfilled}, 32'd0);
      chk("midrst_fetched", l2_fetched_word, 32'd0);
      l2_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("midrst_nopulse", {31'b0, l2_req_fulfilled}, 32'd0);
      end
      run_req("load80_after_rst", LOAD, 32'h0000_0080, 32'h0, FILL);
      run_req("load40_after_rst", LOAD, 32'h0000_0040, 32'h0, FILL);

      // Unknown type reads like a load and never writes.
      run_req("store48", STORE, 32'h0000_0048, 32'h1111_2222, FILL);
      run_req("other_type48", memory_operation_e'(2'b11), 32'h0000_0048, 32'h9999_9999,
              32'h1111_2222);
      run_req("load48_nowrite", LOAD, 32'h0000_0048, 32'h0, 32'h1111_2222);

`ifdef L2_MEM_STATS_EN
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("stats_rst_load", load_count, 32'd0);
      chk("stats_rst_store", store_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_req("st_load1", LOAD, 32'h0000_0040, 32'h0, FILL);
      run_req("st_store1", STORE, 32'h0000_0040, 32'h0000_0001, FILL);
      run_req("st_load2", LOAD, 32'h0000_0040, 32'h0, 32'h0000_0001);
      @(negedge clk);
      l2_req_type    = STORE;
      l2_req_address = 32'h0000_0044;
      l2_req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      l2_req_valid = 1'b0;
      repeat (4) @(posedge clk);
      run_req("st_load3", LOAD, 32'h0000_0044, 32'h0, FILL);
      chk("stats_load_count", load_count, 32'd3);
      chk("stats_store_count", store_count, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 Parameter XLEN, 32, data/address width in bits.
REQ-002 Parameter NUM_WORDS, 1024, backing-store depth in words; power of two.
REQ-003 Parameter LATENCY, 4, rising edges from acceptance to response; legal range 1..15.
REQ-004 Parameter FILL_WORD, 32'hABAC_0012, data returned for never-written words.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 l2_req_address  input  XLEN  byte address from dcache.
REQ-008 l2_req_type  input  memory_operation_e  LOAD or STORE.
REQ-009 l2_req_valid  input  1  request present; held stable by initiator until l2_req_fulfilled.
REQ-010 l2_word_to_store  input  XLEN  store data.
REQ-011 l2_fetched_word  output  XLEN  load data; valid while l2_req_fulfilled is high.
REQ-012 l2_req_fulfilled  output  1  one-cycle completion pulse for LOAD and STORE.

Function
REQ-013 Word index = l2_req_address[log2(NUM_WORDS)+1:2]; bits [1:0] and upper bits ignored (aliasing wrap-around).
REQ-014 FSM states IDLE, WAIT, RESPOND.
REQ-015 IDLE: valid sampled high -> latch address, type, store data; load latency counter; go WAIT (or RESPOND directly when LATENCY=1).
REQ-016 WAIT: counter decrements each edge; at the LATENCY-th edge counting the acceptance edge as 1st -> RESPOND.
REQ-017 WAIT with valid sampled low -> abort to IDLE; no write, no pulse.
REQ-018 On the edge entering RESPOND: STORE writes latched data and sets the word's written bit; LOAD registers stored word, or FILL_WORD if written bit clear, into l2_fetched_word.
REQ-019 RESPOND: l2_req_fulfilled high for exactly one cycle; inputs ignored; next edge -> IDLE unconditionally.
REQ-020 Back-to-back throughput: one request per LATENCY+1 cycles; request held across RESPOND is sampled again in IDLE.
REQ-021 l2_fetched_word holds last load value between loads; unchanged by STORE.
REQ-022 Store then load to the same word returns the stored data (write visible before next accept).
REQ-023 l2_req_type values other than LOAD/STORE complete as LOAD with no write.

Reset
REQ-024 Reset asserted: state IDLE, counter 0, l2_req_fulfilled 0, l2_fetched_word 0, all written bits cleared, immediately and regardless of clk.
REQ-025 Reset mid-WAIT or mid-RESPOND: in-flight request dropped, no write, no pulse; first acceptance at first edge with reset low.
REQ-026 Storage array contents not reset; reads after reset return FILL_WORD until rewritten.

Configuration
REQ-027 Macro L2_MEM_STATS_EN defined: outputs load_count and store_count (32 bits each) present, incremented on each LOAD/STORE RESPOND entry, reset to 0, saturating at 32'hFFFF_FFFF.
REQ-028 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-029 LATENCY=4, LOAD 0x0000_0040 after reset -> fulfilled pulse 4 edges after accept, l2_fetched_word=32'hABAC_0012, one cycle wide.
REQ-030 STORE 0x0000_0040 data 32'hDEAD_BEEF then LOAD 0x0000_0043 -> fetched 32'hDEAD_BEEF; store pulse leaves fetched word unchanged.
REQ-031 NUM_WORDS=1024, STORE 0x0000_1044 data 32'h1234_5678, LOAD 0x0000_0044 -> 32'h1234_5678 (alias wrap).
REQ-032 LOAD accepted, valid dropped at edge 2 of WAIT -> no pulse, FSM IDLE, next LOAD completes normally.
REQ-033 Reset pulsed mid-WAIT of a STORE to 0x80 -> no pulse; subsequent LOAD 0x80 returns 32'hABAC_0012.
REQ-034 L2_MEM_STATS_EN defined, 3 LOADs + 2 STOREs (one aborted) -> load_count=3, store_count=1.
